// File: rtl/latex_line_streamer_if.sv
// Request, pointer-table, character-ROM and character-stream signals of the LaTeX line streamer.
// The slave modport is the streamer; the master modport is its environment.
interface latex_line_streamer_if #(
  parameter int CHAR_W = 8,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 8,
  parameter int LINE_W = 6,
  parameter int LEN_W  = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic [LINE_W-1:0]       req_line;
  logic                    req_side;
  logic                    loop_en;
  logic                    abort;
  logic [LINE_W:0]         ptr_line;
  logic [LEN_W+ADDR_W-1:0] ptr_entry;
  logic [ADDR_W-1:0]       mem_addr;
  logic [WORD_W-1:0]       mem_dout;
  logic                    out_valid;
  logic                    out_ready;
  logic [CHAR_W-1:0]       out_char;
  logic                    out_last;
  logic                    busy;
  logic [2:0]              state_dbg;

  // A character transfers on a cycle where out_valid && out_ready; once out_valid
  // is high, out_char/out_last hold until that transfer (or abort/rst). Requests
  // transfer on req_valid && req_ready.
  modport slave (
    input  req_valid, req_line, req_side, loop_en, abort, ptr_entry, mem_dout, out_ready,
    output req_ready, ptr_line, mem_addr, out_valid, out_char, out_last, busy, state_dbg
  );

  modport master (
    output req_valid, req_line, req_side, loop_en, abort, ptr_entry, mem_dout, out_ready,
    input  req_ready, ptr_line, mem_addr, out_valid, out_char, out_last, busy, state_dbg
  );
endinterface

// File: rtl/latex_line_streamer.sv
// Streams one packed-ASCII LaTeX line (function or transform side) as valid/ready characters,
// fetching packed words from a synchronous ROM and optionally replaying the line.
module latex_line_streamer #(
  parameter int CHAR_W = 8,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 8,
  parameter int LINE_W = 6,
  parameter int LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  latex_line_streamer_if.slave  bus
);
  localparam int CPW   = WORD_W / CHAR_W;
  localparam int IDX_W = $clog2(CPW + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_FETCH  = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                side_q, side_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   word_q, word_d;

  logic [LEN_W-1:0]    ptr_len;
  logic [ADDR_W-1:0]   ptr_start;
  logic                emit_valid;

  assign ptr_len   = bus.ptr_entry[LEN_W+ADDR_W-1 -: LEN_W];
  assign ptr_start = bus.ptr_entry[ADDR_W-1:0];

  // mem_addr is loaded on entry to FETCH so the ROM samples it during FETCH and
  // its data is present during WAIT.
  always_comb begin
    state_d    = state_q;
    side_d     = side_q;
    line_d     = line_q;
    len_d      = len_q;
    rem_d      = rem_q;
    start_d    = start_q;
    cur_d      = cur_q;
    mem_addr_d = mem_addr_q;
    idx_d      = idx_q;
    word_d     = word_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          side_d  = bus.req_side;
          line_d  = bus.req_line;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        len_d   = ptr_len;
        rem_d   = ptr_len;
        start_d = ptr_start;
        cur_d   = ptr_start;
        if (ptr_len == '0) begin
          state_d = S_IDLE;
        end else begin
          mem_addr_d = ptr_start;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        word_d  = bus.mem_dout;
        idx_d   = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          rem_d  = rem_q - 1'b1;
          idx_d  = idx_q + 1'b1;
          word_d = word_q << CHAR_W;
          if (rem_q == LEN_W'(1)) begin
            if (bus.loop_en) begin
              rem_d      = len_q;
              cur_d      = start_q;
              mem_addr_d = start_q;
              state_d    = S_FETCH;
            end else begin
              state_d = S_IDLE;
            end
          end else if (idx_d == IDX_W'(CPW)) begin
            cur_d      = cur_q + 1'b1;
            mem_addr_d = cur_q + 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      side_q     <= 1'b0;
      line_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      start_q    <= '0;
      cur_q      <= '0;
      mem_addr_q <= '0;
      idx_q      <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      side_q     <= side_d;
      line_q     <= line_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      start_q    <= start_d;
      cur_q      <= cur_d;
      mem_addr_q <= mem_addr_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
    end
  end

  // Abort masks out_valid in its own cycle so a cancelled character never transfers.
  assign emit_valid    = (state_q == S_EMIT) && !bus.abort;
  assign bus.out_valid = emit_valid;
  assign bus.out_char  = (state_q == S_EMIT) ? word_q[WORD_W-1 -: CHAR_W] : '0;
  assign bus.out_last  = emit_valid && (rem_q == LEN_W'(1));
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.ptr_line  = {side_q, line_q};
  assign bus.mem_addr  = mem_addr_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_latex_line_streamer.sv
// Directed bench for latex_line_streamer: latency, stalls, empty line, address wrap,
// side selection, loop replay, abort and mid-line reset.
module tb_latex_line_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc;
  logic [8:0]  exp_q[$];
  logic [15:0] rom [256];

  latex_line_streamer_if bus ();

  latex_line_streamer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous character ROM and combinational pointer table.
  always @(posedge clk) bus.mem_dout <= rom[bus.mem_addr];

  always_comb begin
    bus.ptr_entry = 16'h0000;
    case (bus.ptr_line)
      7'h01: bus.ptr_entry = {8'd5, 8'h10};
      7'h02: bus.ptr_entry = {8'd0, 8'h40};
      7'h43: bus.ptr_entry = {8'd4, 8'hFF};
      7'h41: bus.ptr_entry = {8'd2, 8'h30};
      7'h04: bus.ptr_entry = {8'd3, 8'h20};
      default: bus.ptr_entry = 16'h0000;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic side, input logic [5:0] line);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_side  = side;
    bus.req_line  = line;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0 repeating.
  task automatic stream(input string tag, input int n, input int mode, input int budget, output int k);
    int   got;
    logic stalled;
    logic [8:0] held;
    logic [8:0] e;
    got = 0;
    stalled = 1'b0;
    held = '0;
    k = 0;
    while (got < n && k < budget) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      if (stalled) chk({tag, "_stall_hold"}, 32'({bus.out_valid, bus.out_last, bus.out_char}), 32'({1'b1, held}));
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        chk({tag, "_char"}, 32'({bus.out_last, bus.out_char}), 32'(e));
        got++;
        stalled = 1'b0;
      end else if (bus.out_valid) begin
        stalled = 1'b1;
        held = {bus.out_last, bus.out_char};
      end
      tick();
      k++;
    end
    bus.out_ready = 1'b0;
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  task automatic push_line1();
    exp_q.push_back(9'h028);
    exp_q.push_back(9'h073);
    exp_q.push_back(9'h02B);
    exp_q.push_back(9'h061);
    exp_q.push_back(9'h129);
  endtask

  task automatic push_xyz();
    exp_q.push_back(9'h078);
    exp_q.push_back(9'h079);
    exp_q.push_back(9'h17A);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h10] = 16'h2873;
    rom[8'h11] = 16'h2B61;
    rom[8'h12] = 16'h2900;
    rom[8'hFF] = 16'h4142;
    rom[8'h00] = 16'h4344;
    rom[8'h30] = 16'h5354;
    rom[8'h20] = 16'h7879;
    rom[8'h21] = 16'h7A00;
    bus.req_valid = 1'b0;
    bus.req_line  = '0;
    bus.req_side  = 1'b0;
    bus.loop_en   = 1'b0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();

    // Reset values
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_char", 32'(bus.out_char), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ptr_line", 32'(bus.ptr_line), 32'd0);
    rst = 1'b0;
    tick();

    // Line 1 function side: latency, ignored request while busy, refill bubbles
    send_req(1'b0, 6'd1);
    chk("t1_busy_lookup", 32'(bus.busy), 32'd1);
    chk("t1_req_ready_lookup", 32'(bus.req_ready), 32'd0);
    chk("t1_ptr_line", 32'(bus.ptr_line), 32'h01);
    tick();
    chk("t1_valid_c2", 32'(bus.out_valid), 32'd0);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'h10);
    bus.req_valid = 1'b1;
    bus.req_line  = 6'd2;
    tick();
    chk("t1_valid_c3", 32'(bus.out_valid), 32'd0);
    chk("t1_ptr_line_hold", 32'(bus.ptr_line), 32'h01);
    bus.req_valid = 1'b0;
    tick();
    chk("t1_valid_c4", 32'(bus.out_valid), 32'd1);
    push_line1();
    stream("t1", 5, 0, 40, cyc);
    chk("t1_cycles", 32'(cyc), 32'd9);
    chk("t1_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_idle_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("t1_no_extra", 32'(bus.out_valid), 32'd0);

    // Same line with out_ready pattern 1,0,0
    send_req(1'b0, 6'd1);
    push_line1();
    stream("t2", 5, 1, 80, cyc);
    chk("t2_idle", 32'(bus.req_ready), 32'd1);

    // Empty line
    send_req(1'b0, 6'd2);
    chk("t3_busy_c1", 32'(bus.busy), 32'd1);
    chk("t3_valid_c1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t3_ready_c2", 32'(bus.req_ready), 32'd1);
    chk("t3_valid_c2", 32'(bus.out_valid), 32'd0);
    chk("t3_busy_c2", 32'(bus.busy), 32'd0);

    // Transform side, start at 0xFF wraps to 0x00
    send_req(1'b1, 6'd3);
    chk("t4_ptr_line", 32'(bus.ptr_line), 32'h43);
    tick();
    chk("t4_mem_addr_ff", 32'(bus.mem_addr), 32'hFF);
    exp_q.push_back(9'h041);
    exp_q.push_back(9'h042);
    exp_q.push_back(9'h043);
    exp_q.push_back(9'h144);
    stream("t4", 4, 0, 40, cyc);
    chk("t4_mem_addr_00", 32'(bus.mem_addr), 32'h00);

    // Transform side of line 1
    send_req(1'b1, 6'd1);
    chk("t5_ptr_line", 32'(bus.ptr_line), 32'h41);
    exp_q.push_back(9'h053);
    exp_q.push_back(9'h154);
    stream("t5", 2, 0, 40, cyc);

    // Loop replay, then drop loop_en
    bus.loop_en = 1'b1;
    send_req(1'b0, 6'd4);
    push_xyz();
    push_xyz();
    stream("t6_loop", 6, 0, 60, cyc);
    chk("t6_still_busy", 32'(bus.busy), 32'd1);
    bus.loop_en = 1'b0;
    push_xyz();
    stream("t6_stop", 3, 0, 40, cyc);
    chk("t6_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_idle_ready", 32'(bus.req_ready), 32'd1);

    // Abort while emitting mid-line
    send_req(1'b0, 6'd1);
    exp_q.push_back(9'h028);
    stream("t7_pre", 1, 0, 40, cyc);
    chk("t7_in_emit", 32'(bus.state_dbg), 32'd4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t7_valid", 32'(bus.out_valid), 32'd0);
    chk("t7_last", 32'(bus.out_last), 32'd0);
    chk("t7_busy", 32'(bus.busy), 32'd0);
    send_req(1'b0, 6'd4);
    push_xyz();
    stream("t7_post", 3, 0, 40, cyc);

    // Reset during WAIT
    send_req(1'b0, 6'd1);
    tick();
    tick();
    chk("t8_in_wait", 32'(bus.state_dbg), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t8_valid", 32'(bus.out_valid), 32'd0);
    chk("t8_busy", 32'(bus.busy), 32'd0);
    chk("t8_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("t8_ptr_line", 32'(bus.ptr_line), 32'd0);
    send_req(1'b1, 6'd1);
    exp_q.push_back(9'h053);
    exp_q.push_back(9'h154);
    stream("t8_post", 2, 0, 40, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
